// File: rtl/wb_accel_mbox_pkg.sv
// Shared constants for the accelerator mailbox: register offsets, bit
// positions inside STATUS / IRQ registers, run FSM encoding, count saturation.
package wb_accel_mbox_pkg;

  // Register index taken from wb_adr_i[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_IRQ_EN   = 3'd2;
  localparam logic [2:0] REG_IRQ_STAT = 3'd3;
  localparam logic [2:0] REG_DIN      = 3'd4;
  localparam logic [2:0] REG_DOUT     = 3'd5;

  // CTRL command bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  // STATUS bit positions
  localparam int ST_BUSY        = 0;
  localparam int ST_IN_FULL     = 1;
  localparam int ST_IN_EMPTY    = 2;
  localparam int ST_OUT_FULL    = 3;
  localparam int ST_OUT_EMPTY   = 4;
  localparam int ST_IN_CNT_LSB  = 8;
  localparam int ST_OUT_CNT_LSB = 16;

  // IRQ_EN / IRQ_STAT bit positions
  localparam int IRQ_DONE     = 0;
  localparam int IRQ_TIMEOUT  = 1;
  localparam int IRQ_OVERFLOW = 2;
  localparam int IRQ_W        = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // FIFO counts are up to 9 bits wide; STATUS only has 8 bits per count.
  function automatic logic [7:0] sat_cnt8(input logic [15:0] cnt);
    return (cnt > 16'd255) ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/wb_accel_fifo.sv
// Synchronous FIFO with push/pop/flush. Push is ignored when full and pop is
// ignored when empty; flush empties the FIFO and wins over push/pop.
module wb_accel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_accel_mbox.sv
// Wishbone B3 slave mailbox for a streaming accelerator: control/status and
// IRQ registers, input/output stream FIFOs, IDLE/RUN sequencer with watchdog.
module wb_accel_mbox
  import wb_accel_mbox_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16,
  parameter int TIMEOUT    = 0
) (
  input  logic                      clk,
  input  logic                      rst_sys_n,
  input  logic [31:0]               wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic                      acc_start,
  input  logic                      acc_done,
  output logic [DATA_WIDTH-1:0]     acc_in_data,
  output logic                      acc_in_valid,
  input  logic                      acc_in_ready,
  input  logic [DATA_WIDTH-1:0]     acc_out_data,
  input  logic                      acc_out_valid,
  output logic                      acc_out_ready,
  output logic                      irq
);

  localparam int          IN_CW   = $clog2(IN_DEPTH) + 1;
  localparam int          OUT_CW  = $clog2(OUT_DEPTH) + 1;
  localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  // Control state
  fsm_t             r_state;
  fsm_t             w_state_nxt;
  logic [31:0]      r_wd;
  logic [31:0]      w_wd_nxt;
  logic             r_acc_start;
  logic             w_start_pulse;
  logic             w_done_set;
  logic             w_to_set;
  logic             r_rst_done;

  // Bus side
  logic             r_ack;
  logic             r_err;
  logic [DATA_WIDTH-1:0] r_dat;
  logic             w_req;
  logic [2:0]       w_reg_idx;
  logic             w_sel_all;
  logic             w_err_req;
  logic             w_din_push;
  logic             w_dout_pop;
  logic             w_ctrl_wr;
  logic             w_en_wr;
  logic             w_w1c_wr;
  logic             w_ovf_set;
  logic             w_start_cmd;
  logic             w_clear_cmd;
  logic [31:0]      w_rdata32;
  logic [31:0]      w_status;

  // IRQ
  logic [IRQ_W-1:0] r_irq_en;
  logic [IRQ_W-1:0] r_irq_stat;
  logic [IRQ_W-1:0] w_irq_set;
  logic [IRQ_W-1:0] w_w1c_mask;
  logic             r_irq;

  // FIFO interfaces
  logic [DATA_WIDTH-1:0] w_in_head;
  logic                  w_in_full;
  logic                  w_in_empty;
  logic [IN_CW-1:0]      w_in_count;
  logic                  w_in_pop;
  logic [DATA_WIDTH-1:0] w_out_head;
  logic                  w_out_full;
  logic                  w_out_empty;
  logic [OUT_CW-1:0]     w_out_count;
  logic                  w_out_push;
  logic                  w_unused;

  assign w_unused  = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0]};
  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_reg_idx = wb_adr_i[4:2];
  assign w_sel_all = &wb_sel_i;

  assign w_start_cmd = w_ctrl_wr & wb_dat_i[CTRL_START];
  assign w_clear_cmd = w_ctrl_wr & wb_dat_i[CTRL_CLEAR] & (r_state == IDLE);
  assign w_in_pop    = ~w_in_empty & acc_in_ready;
  assign w_out_push  = acc_out_valid & acc_out_ready;
  assign w_w1c_mask  = w_w1c_wr ? wb_dat_i[IRQ_W-1:0] : '0;

  wb_accel_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst_n   (rst_sys_n),
    .i_push  (w_din_push),
    .i_din   (wb_dat_i),
    .i_pop   (w_in_pop),
    .i_flush (w_clear_cmd),
    .o_dout  (w_in_head),
    .o_full  (w_in_full),
    .o_empty (w_in_empty),
    .o_count (w_in_count)
  );

  wb_accel_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_sys_n),
    .i_push  (w_out_push),
    .i_din   (acc_out_data),
    .i_pop   (w_dout_pop),
    .i_flush (w_clear_cmd),
    .o_dout  (w_out_head),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_count)
  );

  // STATUS word assembled from live FIFO flags and the run state
  always_comb begin
    w_status                            = '0;
    w_status[ST_BUSY]                   = (r_state == RUN);
    w_status[ST_IN_FULL]                = w_in_full;
    w_status[ST_IN_EMPTY]               = w_in_empty;
    w_status[ST_OUT_FULL]               = w_out_full;
    w_status[ST_OUT_EMPTY]              = w_out_empty;
    w_status[ST_IN_CNT_LSB +: 8]        = sat_cnt8(16'(w_in_count));
    w_status[ST_OUT_CNT_LSB +: 8]       = sat_cnt8(16'(w_out_count));
  end

  // Address decode: classify the access as ack or err and raise side-effect strobes
  always_comb begin
    w_err_req  = 1'b0;
    w_din_push = 1'b0;
    w_dout_pop = 1'b0;
    w_ctrl_wr  = 1'b0;
    w_en_wr    = 1'b0;
    w_w1c_wr   = 1'b0;
    w_ovf_set  = 1'b0;
    w_rdata32  = '0;
    if (w_req) begin
      case (w_reg_idx)
        REG_CTRL: begin
          if (wb_we_i) begin
            // clear is only legal while idle; a rejected write has no effect at all
            if (wb_sel_i[0] && wb_dat_i[CTRL_CLEAR] && (r_state == RUN)) begin
              w_err_req = 1'b1;
            end else begin
              w_ctrl_wr = wb_sel_i[0];
            end
          end
        end
        REG_STATUS: begin
          if (wb_we_i) w_err_req = 1'b1;
          else         w_rdata32 = w_status;
        end
        REG_IRQ_EN: begin
          if (wb_we_i) w_en_wr = wb_sel_i[0];
          else         w_rdata32[IRQ_W-1:0] = r_irq_en;
        end
        REG_IRQ_STAT: begin
          if (wb_we_i) w_w1c_wr = wb_sel_i[0];
          else         w_rdata32[IRQ_W-1:0] = r_irq_stat;
        end
        REG_DIN: begin
          if (!wb_we_i || !w_sel_all) begin
            w_err_req = 1'b1;
          end else if (w_in_full) begin
            w_err_req = 1'b1;
            w_ovf_set = 1'b1;
          end else begin
            w_din_push = 1'b1;
          end
        end
        REG_DOUT: begin
          if (wb_we_i || !w_sel_all || w_out_empty) begin
            w_err_req = 1'b1;
          end else begin
            w_dout_pop                  = 1'b1;
            w_rdata32[DATA_WIDTH-1:0]   = w_out_head;
          end
        end
        default: w_err_req = 1'b1;
      endcase
    end
  end

  // Bus response: single-cycle ack/err with read data captured alongside
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req & ~w_err_req;
      r_err <= w_req & w_err_req;
      r_dat <= (w_req && !w_err_req && !wb_we_i) ? w_rdata32[DATA_WIDTH-1:0] : '0;
    end
  end

  // Run sequencer next state: start launches, done or watchdog expiry returns to idle
  always_comb begin
    w_state_nxt   = r_state;
    w_wd_nxt      = r_wd;
    w_start_pulse = 1'b0;
    w_done_set    = 1'b0;
    w_to_set      = 1'b0;
    case (r_state)
      IDLE: begin
        w_wd_nxt = '0;
        if (w_start_cmd) begin
          w_state_nxt   = RUN;
          w_start_pulse = 1'b1;
        end
      end
      RUN: begin
        if (acc_done) begin
          w_state_nxt = IDLE;
          w_done_set  = 1'b1;
        end else if ((TIMEOUT > 0) && (r_wd == WD_LAST)) begin
          w_state_nxt = IDLE;
          w_to_set    = 1'b1;
        end else if (TIMEOUT > 0) begin
          w_wd_nxt = r_wd + 32'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Run sequencer state, watchdog and the start pulse that marks the first RUN cycle
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state     <= IDLE;
      r_wd        <= '0;
      r_acc_start <= 1'b0;
      r_rst_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wd        <= w_wd_nxt;
      r_acc_start <= w_start_pulse;
      r_rst_done  <= 1'b1;
    end
  end

  // Interrupt sources
  always_comb begin
    w_irq_set               = '0;
    w_irq_set[IRQ_DONE]     = w_done_set;
    w_irq_set[IRQ_TIMEOUT]  = w_to_set;
    w_irq_set[IRQ_OVERFLOW] = w_ovf_set;
  end

  // IRQ registers: a new event beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_en_wr) begin
        r_irq_en <= wb_dat_i[IRQ_W-1:0];
      end
      r_irq_stat <= (r_irq_stat & ~w_w1c_mask) | w_irq_set;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  assign wb_ack_o      = r_ack;
  assign wb_err_o      = r_err;
  assign wb_rty_o      = 1'b0;
  assign wb_dat_o      = r_dat;
  assign acc_start     = r_acc_start;
  assign acc_in_valid  = ~w_in_empty;
  assign acc_in_data   = w_in_empty ? '0 : w_in_head;
  // held low while in reset so every output is quiet until the block is live
  assign acc_out_ready = r_rst_done & ~w_out_full;
  assign irq           = r_irq;

endmodule

// File: tb/tb_wb_accel_mbox.sv
module tb_wb_accel_mbox;

  localparam int DEPTH = 16;
  localparam int TMO   = 100;

  logic        clk = 1'b0;
  logic        rst_sys_n;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] wb_dat_o;
  logic        acc_start, acc_done;
  logic [31:0] acc_in_data;
  logic        acc_in_valid, acc_in_ready;
  logic [31:0] acc_out_data;
  logic        acc_out_valid, acc_out_ready;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_in[$];
  logic [31:0] m_out[$];
  logic [2:0]  m_stat;
  logic [2:0]  m_en;
  logic        m_busy;

  always #5 clk = ~clk;

  wb_accel_mbox #(
    .DATA_WIDTH(32), .IN_DEPTH(DEPTH), .OUT_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_sys_n(rst_sys_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
    .acc_start(acc_start), .acc_done(acc_done),
    .acc_in_data(acc_in_data), .acc_in_valid(acc_in_valid), .acc_in_ready(acc_in_ready),
    .acc_out_data(acc_out_data), .acc_out_valid(acc_out_valid), .acc_out_ready(acc_out_ready),
    .irq(irq)
  );

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = m_busy;
    s[1]     = (m_in.size() == DEPTH);
    s[2]     = (m_in.size() == 0);
    s[3]     = (m_out.size() == DEPTH);
    s[4]     = (m_out.size() == 0);
    s[15:8]  = 8'(m_in.size());
    s[23:16] = 8'(m_out.size());
    return s;
  endfunction

  task automatic model_reset();
    m_in.delete();
    m_out.delete();
    m_stat = '0;
    m_en   = '0;
    m_busy = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one Wishbone access and waits (bounded) for ack or err
  task automatic bus(input logic we, input logic [2:0] idx, input logic [31:0] dat,
                     input logic [3:0] sel, output logic ack, output logic err,
                     output logic [31:0] rdat);
    wb_adr_i = {27'h0, idx, 2'b00};
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    ack  = 1'b0;
    err  = 1'b0;
    rdat = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o || wb_err_o) begin
        ack  = wb_ack_o;
        err  = wb_err_o;
        rdat = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    checks++;
    if (!(ack || err)) begin
      failures++;
      $display("FAIL bus_response idx=%0d got no ack/err within 8 cycles", idx);
    end
  endtask

  task automatic test_reset();
    logic a, e;
    logic [31:0] d;
    rst_sys_n = 1'b0;
    #23;
    checks++;
    if ({wb_ack_o, wb_err_o, wb_rty_o, acc_start, acc_in_valid, acc_out_ready, irq} !== 7'b0 ||
        wb_dat_o !== 32'h0 || acc_in_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got ctl=%b dat=%h in=%h exp all zero",
               {wb_ack_o, wb_err_o, wb_rty_o, acc_start, acc_in_valid, acc_out_ready, irq},
               wb_dat_o, acc_in_data);
    end
    @(negedge clk);
    rst_sys_n = 1'b1;
    tick(2);
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (a !== 1'b1 || d !== exp_status()) begin
      failures++;
      $display("FAIL reset_status got ack=%b %h exp ack=1 %h", a, d, exp_status());
    end
    bus(1'b0, 3'd3, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_irq_stat got %h exp 0", d);
    end
  endtask

  task automatic test_din_order();
    logic a, e;
    logic [31:0] d, x;
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    acc_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 3'd4, vals[i], 4'hF, a, e, d);
      m_in.push_back(vals[i]);
      checks++;
      if (a !== 1'b1 || e !== 1'b0) begin
        failures++;
        $display("FAIL din_write_ack got ack=%b err=%b exp 1/0", a, e);
      end
    end
    acc_in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = m_in.pop_front();
      checks++;
      if (acc_in_valid !== 1'b1 || acc_in_data !== x) begin
        failures++;
        $display("FAIL din_stream_order got v=%b %h exp v=1 %h", acc_in_valid, acc_in_data, x);
      end
      tick(1);
    end
    acc_in_ready = 1'b0;
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL din_drained_status got %h exp %h", d, exp_status());
    end
  endtask

  task automatic test_overflow();
    logic a, e;
    logic [31:0] d, x;
    acc_in_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      x = $urandom;
      bus(1'b1, 3'd4, x, 4'hF, a, e, d);
      m_in.push_back(x);
      checks++;
      if (a !== 1'b1) begin
        failures++;
        $display("FAIL fill_ack entry=%0d got ack=%b exp 1", i, a);
      end
    end
    bus(1'b1, 3'd4, $urandom, 4'hF, a, e, d);
    m_stat[2] = 1'b1;
    checks++;
    if (e !== 1'b1 || a !== 1'b0) begin
      failures++;
      $display("FAIL overflow_err got ack=%b err=%b exp 0/1", a, e);
    end
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL full_status got %h exp %h", d, exp_status());
    end
    bus(1'b0, 3'd3, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== {29'h0, m_stat}) begin
      failures++;
      $display("FAIL overflow_irq_stat got %h exp %h", d, {29'h0, m_stat});
    end
    bus(1'b1, 3'd2, 32'h4, 4'hF, a, e, d);
    m_en = 3'h4;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_latency got irq=%b exp 0 in enable ack cycle", irq);
    end
    tick(1);
    checks++;
    if (irq !== |(m_stat & m_en)) begin
      failures++;
      $display("FAIL irq_assert got %b exp %b", irq, |(m_stat & m_en));
    end
    acc_in_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      x = m_in.pop_front();
      checks++;
      if (acc_in_data !== x) begin
        failures++;
        $display("FAIL full_drain entry=%0d got %h exp %h", i, acc_in_data, x);
      end
      tick(1);
    end
    acc_in_ready = 1'b0;
    bus(1'b1, 3'd3, 32'h4, 4'hF, a, e, d);
    m_stat[2] = 1'b0;
    tick(1);
    checks++;
    if (irq !== |(m_stat & m_en)) begin
      failures++;
      $display("FAIL irq_w1c got irq=%b exp %b", irq, |(m_stat & m_en));
    end
    x = {29'h0, 3'($urandom)};
    bus(1'b1, 3'd2, x, 4'hF, a, e, d);
    bus(1'b0, 3'd2, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== x) begin
      failures++;
      $display("FAIL irq_en_readback got %h exp %h", d, x);
    end
    bus(1'b1, 3'd2, 32'h0, 4'hF, a, e, d);
    m_en = '0;
  endtask

  task automatic test_done();
    logic a, e;
    logic [31:0] d;
    bus(1'b1, 3'd0, 32'h1, 4'hF, a, e, d);
    m_busy = 1'b1;
    checks++;
    if (a !== 1'b1 || acc_start !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse got ack=%b start=%b exp 1/1", a, acc_start);
    end
    tick(1);
    checks++;
    if (acc_start !== 1'b0) begin
      failures++;
      $display("FAIL start_one_cycle got %b exp 0", acc_start);
    end
    bus(1'b1, 3'd0, 32'h1, 4'hF, a, e, d);
    checks++;
    if (a !== 1'b1 || acc_start !== 1'b0) begin
      failures++;
      $display("FAIL start_in_run got ack=%b start=%b exp 1/0", a, acc_start);
    end
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL busy_status got %h exp %h", d, exp_status());
    end
    acc_done = 1'b1;
    tick(1);
    acc_done = 1'b0;
    m_busy = 1'b0;
    m_stat[0] = 1'b1;
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL done_status got %h exp %h", d, exp_status());
    end
    bus(1'b0, 3'd3, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== {29'h0, m_stat}) begin
      failures++;
      $display("FAIL done_irq_stat got %h exp %h", d, {29'h0, m_stat});
    end
    bus(1'b1, 3'd3, 32'h1, 4'hF, a, e, d);
    m_stat[0] = 1'b0;
    bus(1'b0, 3'd3, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== {29'h0, m_stat}) begin
      failures++;
      $display("FAIL done_w1c got %h exp %h", d, {29'h0, m_stat});
    end
  endtask

  // Start, let TMO-1 cycles pass, then either observe expiry or land acc_done on the last cycle
  task automatic test_timeout(input logic done_at_last);
    logic a, e;
    logic [31:0] d;
    bus(1'b1, 3'd0, 32'h1, 4'hF, a, e, d);
    m_busy = 1'b1;
    tick(TMO - 1);
    if (done_at_last) begin
      acc_done = 1'b1;
      tick(1);
      acc_done = 1'b0;
      m_stat[0] = 1'b1;
    end else begin
      bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
      checks++;
      if (d !== exp_status()) begin
        failures++;
        $display("FAIL busy_last_run_cycle got %h exp %h", d, exp_status());
      end
      m_stat[1] = 1'b1;
    end
    m_busy = 1'b0;
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL end_of_run_status done=%b got %h exp %h", done_at_last, d, exp_status());
    end
    bus(1'b0, 3'd3, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== {29'h0, m_stat}) begin
      failures++;
      $display("FAIL end_of_run_irq_stat done=%b got %h exp %h", done_at_last, d, {29'h0, m_stat});
    end
    bus(1'b1, 3'd3, 32'h7, 4'hF, a, e, d);
    m_stat = '0;
  endtask

  task automatic test_dout();
    logic a, e;
    logic [31:0] d, x;
    acc_out_data  = 32'hA5A5_A5A5;
    acc_out_valid = 1'b1;
    tick(1);
    acc_out_valid = 1'b0;
    m_out.push_back(32'hA5A5_A5A5);
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL out_count_one got %h exp %h", d, exp_status());
    end
    bus(1'b0, 3'd5, 32'h0, 4'hF, a, e, d);
    x = m_out.pop_front();
    checks++;
    if (a !== 1'b1 || d !== x) begin
      failures++;
      $display("FAIL dout_read got ack=%b %h exp ack=1 %h", a, d, x);
    end
    bus(1'b0, 3'd5, 32'h0, 4'hF, a, e, d);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL dout_empty got err=%b %h exp err=1 0", e, d);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      acc_out_data  = $urandom;
      acc_out_valid = 1'b1;
      if (m_out.size() < DEPTH) m_out.push_back(acc_out_data);
      tick(1);
    end
    acc_out_valid = 1'b0;
    checks++;
    if (acc_out_ready !== 1'b0) begin
      failures++;
      $display("FAIL out_full_ready got %b exp 0", acc_out_ready);
    end
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL out_full_status got %h exp %h", d, exp_status());
    end
    while (m_out.size() > 0) begin
      x = m_out.pop_front();
      bus(1'b0, 3'd5, 32'h0, 4'hF, a, e, d);
      checks++;
      if (a !== 1'b1 || d !== x) begin
        failures++;
        $display("FAIL dout_order got ack=%b %h exp %h", a, d, x);
      end
    end
  endtask

  task automatic test_clear();
    logic a, e;
    logic [31:0] d, x;
    acc_in_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = $urandom;
      bus(1'b1, 3'd4, x, 4'hF, a, e, d);
      m_in.push_back(x);
    end
    acc_out_data  = $urandom;
    acc_out_valid = 1'b1;
    tick(1);
    acc_out_valid = 1'b0;
    m_out.push_back(acc_out_data);
    bus(1'b1, 3'd0, 32'h1, 4'hF, a, e, d);
    m_busy = 1'b1;
    bus(1'b1, 3'd0, 32'h2, 4'hF, a, e, d);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("FAIL clear_in_run got err=%b exp 1", e);
    end
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL clear_in_run_status got %h exp %h", d, exp_status());
    end
    acc_done = 1'b1;
    tick(1);
    acc_done = 1'b0;
    m_busy = 1'b0;
    bus(1'b1, 3'd0, 32'h2, 4'hF, a, e, d);
    m_in.delete();
    m_out.delete();
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (a !== 1'b1 || d !== exp_status()) begin
      failures++;
      $display("FAIL clear_idle_status got %h exp %h", d, exp_status());
    end
    bus(1'b1, 3'd4, $urandom, 4'hF, a, e, d);
    bus(1'b1, 3'd0, 32'h3, 4'hF, a, e, d);
    m_busy = 1'b1;
    checks++;
    if (a !== 1'b1 || acc_start !== 1'b1) begin
      failures++;
      $display("FAIL clear_start_pulse got ack=%b start=%b exp 1/1", a, acc_start);
    end
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL clear_then_start_status got %h exp %h", d, exp_status());
    end
    acc_done = 1'b1;
    tick(1);
    acc_done = 1'b0;
    m_busy = 1'b0;
    bus(1'b1, 3'd3, 32'h7, 4'hF, a, e, d);
    m_stat = '0;
  endtask

  task automatic test_errors();
    logic a, e;
    logic [31:0] d;
    logic [7:0] tbl [7];
    // {we, idx[2:0], sel[3:0]}
    tbl = '{8'b1_110_1111, 8'b0_111_1111, 8'b1_001_1111, 8'b1_101_1111,
            8'b0_100_1111, 8'b1_100_0111, 8'b0_101_0011};
    for (int i = 0; i < 7; i++) begin
      bus(tbl[i][7], tbl[i][6:4], $urandom, tbl[i][3:0], a, e, d);
      checks++;
      if (e !== 1'b1 || a !== 1'b0) begin
        failures++;
        $display("FAIL bad_access entry=%0d got ack=%b err=%b exp 0/1", i, a, e);
      end
    end
    bus(1'b0, 3'd0, 32'h0, 4'hF, a, e, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL ctrl_read got ack=%b %h exp ack=1 0", a, d);
    end
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== exp_status()) begin
      failures++;
      $display("FAIL status_after_errors got %h exp %h", d, exp_status());
    end
  endtask

  task automatic test_reset_mid_run();
    logic a, e;
    logic [31:0] d;
    acc_in_ready = 1'b0;
    bus(1'b1, 3'd4, $urandom, 4'hF, a, e, d);
    bus(1'b1, 3'd2, 32'h7, 4'hF, a, e, d);
    bus(1'b1, 3'd0, 32'h1, 4'hF, a, e, d);
    tick(3);
    rst_sys_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if ({wb_ack_o, wb_err_o, wb_rty_o, acc_start, acc_in_valid, acc_out_ready, irq} !== 7'b0 ||
        wb_dat_o !== 32'h0 || acc_in_data !== 32'h0) begin
      failures++;
      $display("FAIL midrun_reset_outputs got ctl=%b dat=%h in=%h exp all zero",
               {wb_ack_o, wb_err_o, wb_rty_o, acc_start, acc_in_valid, acc_out_ready, irq},
               wb_dat_o, acc_in_data);
    end
    @(negedge clk);
    rst_sys_n = 1'b1;
    tick(2);
    bus(1'b0, 3'd1, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== 32'h14) begin
      failures++;
      $display("FAIL midrun_reset_status got %h exp 00000014", d);
    end
    bus(1'b0, 3'd3, 32'h0, 4'hF, a, e, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL midrun_reset_irq_stat got %h exp 0", d);
    end
  endtask

  initial begin
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    acc_done = 1'b0; acc_in_ready = 1'b0;
    acc_out_data = '0; acc_out_valid = 1'b0;
    model_reset();
    test_reset();
    test_din_order();
    test_overflow();
    test_done();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_dout();
    test_clear();
    test_errors();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
